button_conditioner: RTL



---
 rtl/button_conditioner.sv | 105 ++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: per channel 2-flop synchronizer, debounce FSM, registered level and rise pulse.
// Optional release pulse output `fall` is built only when BTN_FALL_EN is defined.
module button_conditioner #(
  parameter int N        = 2,
  parameter int DB_TICKS = 1000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   btn_raw,
  output logic [N-1:0]   level,
  output logic [N-1:0]   rise,
`ifdef BTN_FALL_EN
  output logic [N-1:0]   fall,
`endif
  output logic [2*N-1:0] debug_state
);

  localparam int CW = $clog2(DB_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  state_t        st  [N];
  logic [CW-1:0] cnt [N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      rise  <= '0;
`ifdef BTN_FALL_EN
      fall  <= '0;
`endif
      for (int i = 0; i < N; i++) begin
        st[i]  <= IDLE_LOW;
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= '0;
`ifdef BTN_FALL_EN
      fall  <= '0;
`endif
      for (int i = 0; i < N; i++) begin
        case (st[i])
          IDLE_LOW: begin
            if (sync2[i]) begin
              st[i]  <= WAIT_HIGH;
              cnt[i] <= '0;
            end
          end
          WAIT_HIGH: begin
            // A drop back to 0 before qualification is a glitch: restart silently.
            if (!sync2[i]) begin
              st[i] <= IDLE_LOW;
            end else if (cnt[i] == CNT_LAST) begin
              st[i]    <= HIGH;
              level[i] <= 1'b1;
              rise[i]  <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          HIGH: begin
            if (!sync2[i]) begin
              st[i]  <= WAIT_LOW;
              cnt[i] <= '0;
            end
          end
          WAIT_LOW: begin
            if (sync2[i]) begin
              st[i] <= HIGH;
            end else if (cnt[i] == CNT_LAST) begin
              st[i]    <= IDLE_LOW;
              level[i] <= 1'b0;
`ifdef BTN_FALL_EN
              fall[i]  <= 1'b1;
`endif
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: st[i] <= IDLE_LOW;
        endcase
      end
    end
  end

  always_comb begin
    debug_state = '0;
    for (int i = 0; i < N; i++) begin
      debug_state[2*i +: 2] = st[i];
    end
  end

endmodule
